// File: rtl/fpga_hub_router_pkg.sv
// ---- fpga_hub_router_pkg : shared header fields, IDs and FSM encoding ----
// ---- rev 1.0 ----
`default_nettype none

package fpga_hub_router_pkg;

  localparam int WORD_W   = 64;
  localparam int ID_W     = 8;
  localparam int DEST_MSB = 63;
  localparam int DEST_LSB = 56;
  localparam int SRC_MSB  = 55;
  localparam int SRC_LSB  = 48;

  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fpga_hub_router_rr_arbiter.sv
// ---- rr_arbiter : one-hot round-robin grant starting the search at ptr ----
// ---- rev 1.0 ----
`default_nettype none

module rr_arbiter #(
  parameter int N     = 5,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [PTR_W:0] idx;
  logic           found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(N)) idx = idx - (PTR_W+1)'(N);
      if (!found && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpga_hub_router.sv
// ---- fpga_hub_router : single-word-buffered star router between a root port and leaf FPGAs ----
// ---- rev 1.0 ----
`default_nettype none

module fpga_hub_router
  import fpga_hub_router_pkg::*;
#(
  parameter int          NUM_CHILDREN = 4,
  parameter logic [7:0]  HUB_ID       = 8'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [64*NUM_CHILDREN-1:0] child_rx_data,
  input  logic [NUM_CHILDREN-1:0]    child_rx_valid,
  output logic [NUM_CHILDREN-1:0]    child_rx_ready,
  output logic [64*NUM_CHILDREN-1:0] child_tx_data,
  output logic [NUM_CHILDREN-1:0]    child_tx_valid,
  input  logic [NUM_CHILDREN-1:0]    child_tx_ready,
  input  logic [63:0]                hub_rx_data,
  input  logic                       hub_rx_valid,
  output logic                       hub_rx_ready,
  output logic [63:0]                hub_tx_data,
  output logic                       hub_tx_valid,
  input  logic                       hub_tx_ready,
  output logic                       router_busy,
  output logic [7:0]                 drop_count
);

  localparam int NS    = NUM_CHILDREN + 1;
  localparam int PTR_W = (NS > 1) ? $clog2(NS) : 1;

  state_t            state, state_nxt;
  logic [NS-1:0]     mask, mask_nxt, mask_after, mask_new;
  logic [NS-1:0]     rx_valid_all, rx_ready_all, tx_ready_all, grant;
  logic [63:0]       word, word_nxt, sel_data;
  logic [63:0]       rx_data_all [NS];
  logic [PTR_W-1:0]  ptr, ptr_nxt, grant_idx;
  logic [7:0]        dest;
  logic              can_accept, any_grant, is_drop, drop_inc;

  generate
    for (genvar k = 0; k < NUM_CHILDREN; k++) begin : g_child
      assign rx_data_all[k]            = child_rx_data[k*64 +: 64];
      assign child_tx_data[k*64 +: 64] = word;
    end
  endgenerate

  assign rx_data_all[NUM_CHILDREN] = hub_rx_data;
  assign rx_valid_all   = {hub_rx_valid, child_rx_valid};
  assign tx_ready_all   = {hub_tx_ready, child_tx_ready};
  assign child_rx_ready = rx_ready_all[NUM_CHILDREN-1:0];
  assign hub_rx_ready   = rx_ready_all[NUM_CHILDREN];
  assign child_tx_valid = mask[NUM_CHILDREN-1:0];
  assign hub_tx_valid   = mask[NUM_CHILDREN];
  assign hub_tx_data    = word;
  assign router_busy    = reset && ((state == ST_HOLD) || (|rx_valid_all));

  rr_arbiter #(.N(NS), .PTR_W(PTR_W)) u_arb (
    .req   (rx_valid_all),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    sel_data  = '0;
    grant_idx = '0;
    for (int k = 0; k < NS; k++) begin
      if (grant[k]) begin
        sel_data  = sel_data | rx_data_all[k];
        grant_idx = PTR_W'(k);
      end
    end
  end

  // Hub match wins over the child range if HUB_ID happens to overlap it.
  always_comb begin
    dest     = sel_data[DEST_MSB:DEST_LSB];
    mask_new = '0;
    is_drop  = 1'b0;
    if (dest == HUB_ID) begin
      mask_new[NUM_CHILDREN] = 1'b1;
    end else if (dest == BCAST_ID) begin
      mask_new = {1'b0, {NUM_CHILDREN{1'b1}}} & ~grant;
    end else begin
      for (int k = 0; k < NUM_CHILDREN; k++) begin
        if (dest == 8'(k + 1)) mask_new[k] = 1'b1;
      end
      is_drop = (mask_new == '0);
    end
  end

  // A retiring word frees the buffer in the same cycle, so a new grant can follow.
  always_comb begin
    mask_after   = mask & ~tx_ready_all;
    can_accept   = (state == ST_IDLE) || (mask_after == '0);
    rx_ready_all = (reset && can_accept) ? grant : '0;
    any_grant    = |rx_ready_all;
    state_nxt    = state;
    mask_nxt     = mask_after;
    word_nxt     = word;
    ptr_nxt      = ptr;
    drop_inc     = 1'b0;
    if (can_accept) begin
      state_nxt = ST_IDLE;
      mask_nxt  = '0;
      if (any_grant) begin
        word_nxt = sel_data;
        mask_nxt = mask_new;
        ptr_nxt  = (grant_idx == PTR_W'(NS - 1)) ? '0 : grant_idx + PTR_W'(1);
        drop_inc = is_drop;
        if (mask_new != '0) state_nxt = ST_HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      mask       <= '0;
      word       <= '0;
      ptr        <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      mask  <= mask_nxt;
      word  <= word_nxt;
      ptr   <= ptr_nxt;
      if (drop_inc && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

`default_nettype wire
